// File: rtl/ntt_dit_engine.sv
// Iterative radix-2 DIT NTT: takes a bit-reversed vector, runs one butterfly per clock,
// and presents the natural-order transform behind a valid/ready handshake.
module ntt_dit_engine #(
   parameter int N    = 8,
   parameter int W    = 8,
   parameter int Q    = 17,
   parameter int ROOT = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] vec_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] vec_out,
   output logic           busy
);

   localparam int LOGN = $clog2(N);
   localparam int BW   = LOGN - 1;
   localparam int SW   = $clog2(LOGN);

   localparam logic [W-1:0]   QW = W'(Q);
   localparam logic [W:0]     Q1 = (W+1)'(Q);
   localparam logic [2*W-1:0] Q2 = (2*W)'(Q);

   function automatic logic [N/2*W-1:0] build_tw();
      logic [N/2*W-1:0] tab;
      longint unsigned  acc;
      tab = '0;
      acc = 1;
      for (int unsigned i = 0; i < N/2; i++) begin
         tab[i*W +: W] = W'(acc);
         acc = (acc * longint'(ROOT)) % longint'(Q);
      end
      return tab;
   endfunction

   localparam logic [N/2*W-1:0] TW_TABLE = build_tw();

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [W-1:0]    a      [N];
   logic [W-1:0]    a_next [N];
   logic [SW-1:0]   stage;
   logic [BW-1:0]   bf;

   logic [LOGN-1:0] half, bfx, k, lo, hi, tw_exp;
   logic [SW-1:0]   tw_sh;
   logic [BW-1:0]   tw_idx;
   logic [W-1:0]    tw, t, a_lo, a_hi;
   logic [2*W-1:0]  prod;
   logic [W:0]      sum, diff;
   logic            last_bf, stage_end;

   // Butterfly addressing is derived from a flat per-stage index: bits above half pick the group.
   always_comb begin
      half   = LOGN'(1) << stage;
      bfx    = {1'b0, bf};
      k      = bfx & (half - LOGN'(1));
      lo     = ((bfx & ~(half - LOGN'(1))) << 1) | k;
      hi     = lo | half;
      tw_sh  = SW'(LOGN - 1) - stage;
      tw_exp = k << tw_sh;
      tw_idx = tw_exp[BW-1:0];
      tw     = TW_TABLE[tw_idx*W +: W];
      a_lo   = a[lo];
      a_hi   = a[hi];
      prod   = {{W{1'b0}}, tw} * {{W{1'b0}}, a_hi};
      t      = W'(prod % Q2);
      sum    = {1'b0, a_lo} + {1'b0, t};
      if (sum >= Q1) sum = sum - Q1;
      diff   = {1'b0, a_lo} + Q1 - {1'b0, t};
      if (diff >= Q1) diff = diff - Q1;
      for (int unsigned i = 0; i < N; i++) a_next[i] = a[i];
      a_next[lo] = sum[W-1:0];
      a_next[hi] = diff[W-1:0];
      stage_end  = (bf == BW'(N/2 - 1));
      last_bf    = stage_end && (stage == SW'(LOGN - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = COMPUTE;
         end
         COMPUTE: begin
            busy = 1'b1;
            if (last_bf) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N; i++) a[i] <= '0;
         stage   <= '0;
         bf      <= '0;
         vec_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int unsigned i = 0; i < N; i++) a[i] <= vec_in[i*W +: W] % QW;
               end
            end
            COMPUTE: begin
               for (int unsigned i = 0; i < N; i++) a[i] <= a_next[i];
               if (last_bf) begin
                  stage <= '0;
                  bf    <= '0;
                  for (int unsigned i = 0; i < N; i++) vec_out[i*W +: W] <= a_next[i];
               end else if (stage_end) begin
                  bf    <= '0;
                  stage <= stage + SW'(1);
               end else begin
                  bf <= bf + BW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
